// File: rtl/mem_fetch_sequencer.sv
// Address sequencer for a 10-neuron dense layer: streams x[i] and ten weight
// rows, then one bias read, then signals completion to the downstream MAC.
module mem_fetch_sequencer #(
  parameter int unsigned N_IN   = 784,
  parameter logic [15:0] X_BASE = 16'd0,
  parameter logic [15:0] W_BASE = 16'd1024,
  parameter logic [15:0] B_BASE = 16'd8864
) (
  input  logic         clock_mem,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         acc_ready,
  output logic         rd_en,
  output logic [15:0]  x_addr,
  output logic [159:0] w_addr_flat,
  output logic [159:0] b_addr_flat,
  output logic         data_valid,
  output logic         bias_valid,
  output logic         mac_clr,
  output logic         busy,
  output logic         done
);

  localparam logic [11:0] I_LAST = 12'(N_IN - 32'd1);

  localparam int unsigned X_MAX = 32'(X_BASE) + N_IN - 32'd1;
  localparam int unsigned W_MAX = 32'(W_BASE) + 32'd10 * N_IN - 32'd1;
  localparam int unsigned B_MAX = 32'(B_BASE) + 32'd9;
  localparam bit PARAMS_OK = (N_IN >= 32'd1) && (N_IN <= 32'd4095) &&
                             (X_MAX < 32'd32768) && (W_MAX < 32'd32768) &&
                             (B_MAX < 32'd32768);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    BIAS  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] i_q, i_d;
  logic        rd_en_s;
  logic        data_valid_q, data_valid_d;
  logic        bias_valid_q, bias_valid_d;
  logic        mac_clr_q, mac_clr_d;

  // Next-state, index and read-strobe logic; abort suppresses the read it cancels.
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    rd_en_s      = 1'b0;
    mac_clr_d    = 1'b0;
    data_valid_d = 1'b0;
    bias_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = FETCH;
          i_d       = 12'd0;
          mac_clr_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (acc_ready) begin
          rd_en_s      = 1'b1;
          data_valid_d = 1'b1;
          if (i_q == I_LAST) begin
            state_d = BIAS;
          end else begin
            i_d = i_q + 12'd1;
          end
        end else begin
          state_d = FETCH;
        end
      end
      BIAS: begin
        if (abort) begin
          state_d = IDLE;
        end else if (acc_ready) begin
          rd_en_s      = 1'b1;
          bias_valid_d = 1'b1;
          state_d      = DRAIN;
        end else begin
          state_d = BIAS;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, index and one-cycle-delayed valid/clear flags.
  always_ff @(posedge clock_mem or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      i_q          <= 12'd0;
      data_valid_q <= 1'b0;
      bias_valid_q <= 1'b0;
      mac_clr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      data_valid_q <= data_valid_d;
      bias_valid_q <= bias_valid_d;
      mac_clr_q    <= mac_clr_d;
    end
  end

  // i only moves on an issued read, so addresses hold through stalls.
  assign x_addr = X_BASE + {4'd0, i_q};

  for (genvar k = 0; k < 10; k++) begin : g_neuron
    localparam logic [15:0] W_ROW = 16'(32'(W_BASE) + 32'(k) * N_IN);
    assign w_addr_flat[16*k +: 16] = W_ROW + {4'd0, i_q};
    assign b_addr_flat[16*k +: 16] = B_BASE + 16'(k);
  end

  assign rd_en      = rd_en_s;
  assign data_valid = data_valid_q;
  assign bias_valid = bias_valid_q;
  assign mac_clr    = mac_clr_q;
  assign busy       = (state_q == FETCH) || (state_q == BIAS) || (state_q == DRAIN);
  assign done       = (state_q == DONE);

  // Simulation-only guards: illegal parameter sets and overlapping valid strobes.
  a_params_legal: assert property (@(posedge clock_mem) PARAMS_OK)
    else $error("mem_fetch_sequencer: parameter set produces addresses >= 32768 or bad N_IN");
  a_valid_excl: assert property (@(posedge clock_mem) disable iff (!rst)
    !(data_valid_q && bias_valid_q));

endmodule

// File: tb/tb_mem_fetch_sequencer.sv
// Bench for mem_fetch_sequencer: directed scenarios with literal expectations,
// then random start/abort/stall/reset traffic checked against a count-based model.
module tb_mem_fetch_sequencer;

  localparam int N  = 4;
  localparam int XB = 0;
  localparam int WB = 1024;
  localparam int BB = 8864;

  logic         clock_mem = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         acc_ready = 1'b0;
  logic         rd_en;
  logic [15:0]  x_addr;
  logic [159:0] w_addr_flat;
  logic [159:0] b_addr_flat;
  logic         data_valid, bias_valid, mac_clr, busy, done;

  int tests = 0;
  int fails = 0;

  mem_fetch_sequencer #(
    .N_IN  (N),
    .X_BASE(16'(XB)),
    .W_BASE(16'(WB)),
    .B_BASE(16'(BB))
  ) dut (
    .clock_mem  (clock_mem),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .acc_ready  (acc_ready),
    .rd_en      (rd_en),
    .x_addr     (x_addr),
    .w_addr_flat(w_addr_flat),
    .b_addr_flat(b_addr_flat),
    .data_valid (data_valid),
    .bias_valid (bias_valid),
    .mac_clr    (mac_clr),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock_mem = ~clock_mem;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock_mem);
    #2;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    #1;
    while (!done && n < 60) begin
      cyc();
      #1;
      n++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s: done not seen within 60 cycles, got 0, expected 1", nm);
    end
  endtask

  // Behavioural model: a fetch is "running" from start until the done cycle;
  // reads are counted, the bias read follows N data reads, then 1 drain + 1 done cycle.
  bit m_run = 1'b0;
  int m_cnt = 0;
  int m_post = 0;
  int m_idx = 0;
  bit m_dv = 1'b0, m_bv = 1'b0, m_mc = 1'b0;
  int dv_cnt = 0, bv_cnt = 0;

  always @(negedge clock_mem) begin
    bit e_rd, e_busy, e_done, n_dv, n_bv, n_mc;
    if (!rst) begin
      m_run = 1'b0; m_cnt = 0; m_post = 0; m_idx = 0;
      m_dv = 1'b0; m_bv = 1'b0; m_mc = 1'b0;
      dv_cnt = 0; bv_cnt = 0;
    end
    e_rd   = m_run && (m_post == 0) && acc_ready && !abort && rst;
    e_busy = m_run && (m_post != 2);
    e_done = m_run && (m_post == 2);

    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("mac_clr", 32'(mac_clr), 32'(m_mc));
    chk("data_valid", 32'(data_valid), 32'(m_dv));
    chk("bias_valid", 32'(bias_valid), 32'(m_bv));
    chk("x_addr", 32'(x_addr), 32'(16'(XB + m_idx)));
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("w_addr[%0d]", k + 1), 32'(w_addr_flat[16*k +: 16]),
          32'(16'(WB + k * N + m_idx)));
      chk($sformatf("b_addr[%0d]", k + 1), 32'(b_addr_flat[16*k +: 16]),
          32'(16'(BB + k)));
    end

    if (data_valid) dv_cnt++;
    if (bias_valid) bv_cnt++;
    if (e_done) begin
      chk("dv_pulses", 32'(dv_cnt), 32'(N));
      chk("bv_pulses", 32'(bv_cnt), 32'd1);
    end

    if (rst) begin
      n_dv = e_rd && (m_cnt < N);
      n_bv = e_rd && (m_cnt >= N);
      n_mc = 1'b0;
      if (!m_run) begin
        if (start && !abort) begin
          m_run = 1'b1; m_cnt = 0; m_post = 0; m_idx = 0;
          n_mc = 1'b1; dv_cnt = 0; bv_cnt = 0;
        end
      end else if (abort) begin
        m_run = 1'b0;
      end else if (m_post == 2) begin
        m_run = 1'b0;
      end else if (m_post == 1) begin
        m_post = 2;
      end else if (e_rd) begin
        if (m_cnt < N) begin
          if (m_cnt < N - 1) m_idx++;
          m_cnt++;
        end else begin
          m_post = 1;
        end
      end
      m_dv = n_dv; m_bv = n_bv; m_mc = n_mc;
    end
  end

  initial begin
    cyc(); cyc();
    #1;
    chk("rst_x_addr", 32'(x_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    cyc();

    // Basic fetch with literal address expectations.
    acc_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("lit_mac_clr", 32'(mac_clr), (j == 0) ? 32'd1 : 32'd0);
      chk("lit_rd_en", 32'(rd_en), 32'd1);
      chk("lit_x_seq", 32'(x_addr), 32'(j));
      chk("lit_w2_seq", 32'(w_addr_flat[31:16]), 32'(1028 + j));
      cyc();
    end
    #1;
    chk("lit_bias_rd", 32'(rd_en), 32'd1);
    chk("lit_b10", 32'(b_addr_flat[159:144]), 32'd8873);
    cyc();
    #1;
    chk("lit_drain_rd", 32'(rd_en), 32'd0);
    chk("lit_drain_bv", 32'(bias_valid), 32'd1);
    chk("lit_drain_busy", 32'(busy), 32'd1);
    cyc();
    #1;
    chk("lit_done", 32'(done), 32'd1);
    chk("lit_done_busy", 32'(busy), 32'd0);
    cyc();

    // Stall three cycles at i=2.
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    acc_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("stall_rd", 32'(rd_en), 32'd0);
      chk("stall_x", 32'(x_addr), 32'd2);
      cyc();
    end
    acc_ready = 1'b1;
    #1;
    chk("resume_x", 32'(x_addr), 32'd2);
    wait_done("stall_done");
    cyc();

    // Abort at i=2, then a full fetch.
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    abort = 1'b1; cyc(); abort = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd", 32'(rd_en), 32'd0);
    cyc(); cyc();
    start = 1'b1; cyc(); start = 1'b0;
    wait_done("post_abort_done");
    cyc();

    // Start together with abort in IDLE, then start while busy.
    start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
    #1;
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_mc", 32'(mac_clr), 32'd0);
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    wait_done("busy_start_done");
    cyc();

    // Reset while stalled in BIAS.
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    acc_ready = 1'b0;
    cyc();
    #1;
    chk("in_bias_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rd", 32'(rd_en), 32'd0);
    chk("arst_dv", 32'(data_valid), 32'd0);
    chk("arst_bv", 32'(bias_valid), 32'd0);
    chk("arst_x", 32'(x_addr), 32'd0);
    cyc();
    rst = 1'b1;
    acc_ready = 1'b1;
    cyc(); cyc(); cyc();
    #1;
    chk("after_rst_idle", 32'(busy), 32'd0);

    // Back-to-back: start in the cycle right after done.
    start = 1'b1; cyc(); start = 1'b0;
    wait_done("b2b_first");
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    #1;
    chk("b2b_mac_clr", 32'(mac_clr), 32'd1);
    wait_done("b2b_second");
    cyc();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 19) == 0);
      abort     = ($urandom_range(0, 99) == 0);
      acc_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 499) != 0);
      cyc();
    end
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
